// File: rtl/debounce_pkg.sv
// Shared types for the endstop capture block: debounce and lock FSM state
// encodings plus the width of the per-channel qualified-change counter.
package debounce_pkg;

   typedef enum logic [1:0] {
      STABLE  = 2'd0,
      BOUNCE1 = 2'd1,
      BOUNCE2 = 2'd2
   } dstate_t;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lstate_t;

   localparam int CYC_W = 8;

endpackage

// File: rtl/endstop_capture_multi_if.sv
// Bundle between the endstop pins / step-generator position bus and the
// motion-control register block; the capture block sits on the slave side.
interface endstop_capture_multi_if #(
   parameter int N_CH  = 4,
   parameter int POS_W = 64,
   parameter int TMR_W = 32
);
   import debounce_pkg::*;

   logic [N_CH-1:0]       sig_in;
   logic [N_CH-1:0]       invert;
   logic [N_CH-1:0]       unlock;
   logic [POS_W-1:0]      pos_in;
   logic [TMR_W-1:0]      timeout;
   logic [N_CH-1:0]       sig_out;
   logic [N_CH-1:0]       sig_changed;
   logic [N_CH*POS_W-1:0] pos_out;
   logic [N_CH*TMR_W-1:0] max_bounce;
   logic [N_CH*CYC_W-1:0] cycles;
   logic                  any_changed;

   modport master (
      output sig_in, invert, unlock, pos_in, timeout,
      input  sig_out, sig_changed, pos_out, max_bounce, cycles, any_changed
   );

   modport slave (
      input  sig_in, invert, unlock, pos_in, timeout,
      output sig_out, sig_changed, pos_out, max_bounce, cycles, any_changed
   );

endinterface

// File: rtl/debounce_chan.sv
// One endstop channel: synchroniser, polarity, debounce FSM, lock FSM and
// optional bounce statistics (enabled by defining DEBOUNCE_STATS_EN).
module debounce_chan
   import debounce_pkg::*;
#(
   parameter int POS_W = 64,
   parameter int TMR_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sig_i,
   input  logic             invert_i,
   input  logic             unlock_i,
   input  logic [POS_W-1:0] pos_i,
   input  logic [TMR_W-1:0] timeout_i,
   output logic             sig_o,
   output logic             changed_o,
   output logic [POS_W-1:0] pos_o,
   output logic [TMR_W-1:0] max_bounce_o,
   output logic [CYC_W-1:0] cycles_o
);

   logic [1:0]       sync_q;
   logic             s;
   dstate_t          dstate_q, dstate_d;
   logic [TMR_W-1:0] timer_q, timer_d, timer_inc;
   logic             value_q, value_d;
   logic [POS_W-1:0] start_pos_q, start_pos_d;
   logic             vchg_q, vchg_d;
   lstate_t          lstate_q, lstate_d;
   logic             sig_out_q, sig_out_d;
   logic             changed_q, changed_d;
   logic [POS_W-1:0] pos_out_q, pos_out_d;

   // invert bypasses the synchroniser, so flipping it looks like an input edge
   assign s         = sync_q[1] ^ invert_i;
   assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q      <= '0;
         dstate_q    <= STABLE;
         timer_q     <= '0;
         value_q     <= 1'b0;
         start_pos_q <= '0;
         vchg_q      <= 1'b0;
         lstate_q    <= UNLOCKED;
         sig_out_q   <= 1'b0;
         changed_q   <= 1'b0;
         pos_out_q   <= '0;
      end else begin
         sync_q      <= {sync_q[0], sig_i};
         dstate_q    <= dstate_d;
         timer_q     <= timer_d;
         value_q     <= value_d;
         start_pos_q <= start_pos_d;
         vchg_q      <= vchg_d;
         lstate_q    <= lstate_d;
         sig_out_q   <= sig_out_d;
         changed_q   <= changed_d;
         pos_out_q   <= pos_out_d;
      end
   end

   // Debounce: BOUNCE1 counts time at the new level, BOUNCE2 time back at the old one
   always_comb begin
      dstate_d    = dstate_q;
      timer_d     = timer_q;
      value_d     = value_q;
      start_pos_d = start_pos_q;
      vchg_d      = 1'b0;
      case (dstate_q)
         STABLE: begin
            if (s != value_q) begin
               dstate_d    = BOUNCE1;
               timer_d     = '0;
               start_pos_d = pos_i;
            end
         end
         BOUNCE1: begin
            if (s == value_q) begin
               dstate_d = BOUNCE2;
               timer_d  = '0;
            end else if (timer_q > timeout_i) begin
               value_d  = s;
               vchg_d   = 1'b1;
               dstate_d = STABLE;
            end else begin
               timer_d = timer_inc;
            end
         end
         BOUNCE2: begin
            if (s != value_q) begin
               dstate_d = BOUNCE1;
               timer_d  = '0;
            end else if (timer_q > timeout_i) begin
               dstate_d = STABLE;
            end else begin
               timer_d = timer_inc;
            end
         end
         default: dstate_d = STABLE;
      endcase
   end

   // Lock: first event captures position; unlock beats a coincident event
   always_comb begin
      lstate_d  = lstate_q;
      sig_out_d = sig_out_q;
      changed_d = changed_q;
      pos_out_d = pos_out_q;
      case (lstate_q)
         UNLOCKED: begin
            sig_out_d = value_q;
            if (vchg_q) begin
               lstate_d  = LOCKED;
               pos_out_d = start_pos_q;
               changed_d = 1'b1;
            end
         end
         LOCKED: begin
            if (unlock_i) begin
               lstate_d  = UNLOCKED;
               changed_d = 1'b0;
               sig_out_d = value_q;
            end
         end
         default: lstate_d = UNLOCKED;
      endcase
   end

   assign sig_o     = sig_out_q;
   assign changed_o = changed_q;
   assign pos_o     = pos_out_q;

`ifdef DEBOUNCE_STATS_EN
   logic             bounce_end;
   logic             count_evt;
   logic [TMR_W-1:0] max_bounce_q, max_bounce_d;
   logic [CYC_W-1:0] cycles_q, cycles_d;

   assign bounce_end = ((dstate_q == BOUNCE1) && (s == value_q)) ||
                       ((dstate_q == BOUNCE2) && (s != value_q));
   assign count_evt  = vchg_q && !((lstate_q == LOCKED) && unlock_i);

   // A bounce-interval update in the same cycle as unlock takes priority over the clear
   always_comb begin
      max_bounce_d = max_bounce_q;
      cycles_d     = cycles_q;
      if (bounce_end) begin
         if (timer_q > max_bounce_q) max_bounce_d = timer_q;
      end else if (unlock_i) begin
         max_bounce_d = '0;
      end
      if (count_evt) cycles_d = cycles_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         max_bounce_q <= '0;
         cycles_q     <= '0;
      end else begin
         max_bounce_q <= max_bounce_d;
         cycles_q     <= cycles_d;
      end
   end

   assign max_bounce_o = max_bounce_q;
   assign cycles_o     = cycles_q;
`else
   assign max_bounce_o = '0;
   assign cycles_o     = '0;
`endif

endmodule

// File: rtl/endstop_capture_multi.sv
// N independent endstop capture channels sharing one position bus and timeout.
// Bounce statistics are present only when DEBOUNCE_STATS_EN is defined.
module endstop_capture_multi
   import debounce_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int POS_W = 64,
   parameter int TMR_W = 32
) (
   input logic                    clk,
   input logic                    reset,
   endstop_capture_multi_if.slave bus
);

   logic [N_CH-1:0]       sigOut;
   logic [N_CH-1:0]       changed;
   logic [N_CH*POS_W-1:0] posOut;
   logic [N_CH*TMR_W-1:0] maxBounce;
   logic [N_CH*CYC_W-1:0] cycleCount;

   for (genvar g = 0; g < N_CH; g++) begin : gChan
      debounce_chan #(
         .POS_W (POS_W),
         .TMR_W (TMR_W)
      ) uChan (
         .clk          (clk),
         .reset        (reset),
         .sig_i        (bus.sig_in[g]),
         .invert_i     (bus.invert[g]),
         .unlock_i     (bus.unlock[g]),
         .pos_i        (bus.pos_in),
         .timeout_i    (bus.timeout),
         .sig_o        (sigOut[g]),
         .changed_o    (changed[g]),
         .pos_o        (posOut[g*POS_W +: POS_W]),
         .max_bounce_o (maxBounce[g*TMR_W +: TMR_W]),
         .cycles_o     (cycleCount[g*CYC_W +: CYC_W])
      );
   end

   assign bus.sig_out     = sigOut;
   assign bus.sig_changed = changed;
   assign bus.pos_out     = posOut;
   assign bus.max_bounce  = maxBounce;
   assign bus.cycles      = cycleCount;
   assign bus.any_changed = |changed;

endmodule

// File: tb/tb_endstop_capture_multi.sv
// Directed bench for endstop_capture_multi: clean edge latency, glitch, bounce,
// lock/unlock, invert, timeout saturation and reset; stats expectations follow DEBOUNCE_STATS_EN.
module tb_endstop_capture_multi;

`ifdef DEBOUNCE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   testsRun = 0;
   int   testsFailed = 0;

   always #5 clk = ~clk;

   endstop_capture_multi_if #(.N_CH(4), .POS_W(64), .TMR_W(32)) bus ();

   endstop_capture_multi #(.N_CH(4), .POS_W(64), .TMR_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic logic [63:0] posOut(int ch);
      return bus.pos_out[ch*64 +: 64];
   endfunction

   function automatic logic [31:0] maxBounce(int ch);
      return bus.max_bounce[ch*32 +: 32];
   endfunction

   function automatic logic [7:0] cyc(int ch);
      return bus.cycles[ch*8 +: 8];
   endfunction

   function automatic logic [255:0] statExp(logic [255:0] v);
      return STATS ? v : 256'd0;
   endfunction

   task automatic applyStimulus(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(string tag, logic [255:0] observed, logic [255:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   initial begin
      reset       = 1'b1;
      bus.sig_in  = '0;
      bus.invert  = '0;
      bus.unlock  = '0;
      bus.pos_in  = '0;
      bus.timeout = 32'd4;
      applyStimulus(3);
      reset = 1'b0;
      applyStimulus(1);

      // reset state
      checkOutput("rst_sig_out", bus.sig_out, 0);
      checkOutput("rst_changed", bus.sig_changed, 0);
      checkOutput("rst_pos_out", bus.pos_out, 0);
      checkOutput("rst_any", bus.any_changed, 0);

      // clean edge on ch0, timeout 4: position sampled at third edge, lock at tenth
      bus.sig_in[0] = 1'b1;
      for (int k = 0; k < 9; k++) begin
         bus.pos_in = 64'd98 + 64'(k);
         applyStimulus(1);
      end
      checkOutput("t1_not_yet", bus.sig_changed[0], 0);
      applyStimulus(1);
      checkOutput("t1_changed", bus.sig_changed[0], 1);
      checkOutput("t1_pos", posOut(0), 100);
      checkOutput("t1_sig_out", bus.sig_out[0], 1);
      checkOutput("t1_any", bus.any_changed, 1);
      checkOutput("t1_cycles", cyc(0), statExp(1));

      // 3-cycle glitch on ch1, timeout 10: timer reaches 2 before the level returns
      bus.timeout   = 32'd10;
      bus.sig_in[1] = 1'b1;
      applyStimulus(3);
      bus.sig_in[1] = 1'b0;
      applyStimulus(20);
      checkOutput("t2_changed", bus.sig_changed[1], 0);
      checkOutput("t2_sig_out", bus.sig_out[1], 0);
      checkOutput("t2_max_bounce", maxBounce(1), statExp(2));
      checkOutput("t2_cycles", cyc(1), 0);

      // ch2 toggles 1,0,1 then holds; start position comes from the first edge
      bus.sig_in[2] = 1'b1;
      bus.pos_in    = 64'd500;
      applyStimulus(2);
      bus.sig_in[2] = 1'b0;
      applyStimulus(1);
      bus.pos_in = 64'd600;
      applyStimulus(1);
      bus.sig_in[2] = 1'b1;
      applyStimulus(8);
      bus.pos_in = 64'd700;
      applyStimulus(12);
      checkOutput("t3_changed", bus.sig_changed[2], 1);
      checkOutput("t3_pos", posOut(2), 500);
      checkOutput("t3_sig_out", bus.sig_out[2], 1);
      checkOutput("t3_max_bounce", maxBounce(2), statExp(1));
      checkOutput("t3_ch0_pos_kept", posOut(0), 100);

      // ch0 release / re-assert / release while locked: only cycles moves
      bus.sig_in[0] = 1'b0;
      applyStimulus(20);
      checkOutput("t4_rel_sig_out_held", bus.sig_out[0], 1);
      checkOutput("t4_rel_pos_held", posOut(0), 100);
      checkOutput("t4_rel_cycles", cyc(0), statExp(2));
      bus.sig_in[0] = 1'b1;
      applyStimulus(20);
      checkOutput("t4_re_cycles", cyc(0), statExp(3));
      bus.sig_in[0] = 1'b0;
      applyStimulus(20);
      checkOutput("t4_rel2_cycles", cyc(0), statExp(4));
      checkOutput("t4_rel2_changed", bus.sig_changed[0], 1);
      bus.unlock = 4'b0101;
      applyStimulus(1);
      bus.unlock = 4'b0000;
      checkOutput("t4_unl_changed", bus.sig_changed, 4'b0000);
      checkOutput("t4_unl_sig_out0", bus.sig_out[0], 0);
      checkOutput("t4_unl_sig_out2", bus.sig_out[2], 1);
      checkOutput("t4_unl_pos_held", posOut(0), 100);
      checkOutput("t4_unl_max_clear", maxBounce(2), 0);
      checkOutput("t4_unl_any", bus.any_changed, 0);

      // invert on ch3 lines up with a synchronised edge on ch0: same capture position
      bus.timeout   = 32'd4;
      bus.sig_in[0] = 1'b1;
      bus.pos_in    = 64'd1000;
      applyStimulus(2);
      bus.invert[3] = 1'b1;
      applyStimulus(1);
      bus.pos_in = 64'd2000;
      applyStimulus(6);
      checkOutput("t5_not_yet", bus.sig_changed, 4'b0000);
      applyStimulus(1);
      checkOutput("t5_changed", bus.sig_changed, 4'b1001);
      checkOutput("t5_sig_out3", bus.sig_out[3], 1);
      checkOutput("t5_pos3", posOut(3), 1000);
      checkOutput("t5_pos0", posOut(0), 1000);
      checkOutput("t5_cycles0", cyc(0), statExp(5));
      checkOutput("t5_cycles3", cyc(3), statExp(1));

      // all-ones timeout never qualifies; ch1 is left mid-bounce for the reset check
      bus.timeout   = '1;
      bus.sig_in[1] = 1'b1;
      applyStimulus(30);
      checkOutput("t6_sat_changed", bus.sig_changed[1], 0);
      checkOutput("t6_sat_sig_out", bus.sig_out[1], 0);

      reset = 1'b1;
      applyStimulus(1);
      checkOutput("t6_rst_sig_out", bus.sig_out, 0);
      checkOutput("t6_rst_changed", bus.sig_changed, 0);
      checkOutput("t6_rst_pos", bus.pos_out, 0);
      checkOutput("t6_rst_max", bus.max_bounce, 0);
      checkOutput("t6_rst_cycles", bus.cycles, 0);
      checkOutput("t6_rst_any", bus.any_changed, 0);
      bus.sig_in  = '0;
      bus.invert  = '0;
      bus.timeout = 32'd4;
      applyStimulus(2);
      reset = 1'b0;
      applyStimulus(20);
      checkOutput("t6_post_changed", bus.sig_changed, 0);
      checkOutput("t6_post_sig_out", bus.sig_out, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
